gppcu_instr_dec_pipe: RTL and testbench
=======================================

Name: gppcu_instr_dec_pipe

Overview:
Registered, programmable successor to the combinational GPPCU opcode decoder.
- Opcode-to-control-word table: writable at run time, with a per-entry valid bit and a per-entry extra-latency field.
- Decode path: registered, with valid/ready handshakes on both sides.
- Issue throttling: holds off the next instruction for the programmed number of cycles after long-latency ops (FDIV, FSQRT).
- Sits between instruction fetch and the GPPCU datapath; counts illegal opcodes.

Parameters:
OPC_BITS, 5, opcode width; table depth = 2**OPC_BITS
CW_BITS, 18, control word width (USEREGA,USEREGB,FPOP,ALOP,LMEMRD,LMEMWR,FPOPC[3:0],ALOPC[3:0],BSEL[1:0],GMEMRD,REGWR)
LAT_BITS, 4, width of per-entry extra-latency field
ERRCNT_BITS, 8, width of illegal-opcode counter

Ports:
iCLK  in  1  clock; all logic on rising edge
iRST  in  1  synchronous active-high reset
iValid  in  1  upstream opcode valid
oReady  out  1  stage can accept opcode this cycle
iOPC  in  OPC_BITS  opcode
oValid  out  1  decoded output valid
iReady  in  1  downstream accepts output
oOPC  out  OPC_BITS  opcode of current output
oCW  out  CW_BITS  decoded control word
oIllegal  out  1  current output came from an unprogrammed entry (qualified by oValid)
oBusy  out  1  stage is in the latency stall
oIllCnt  out  ERRCNT_BITS  saturating count of illegal opcodes accepted
iClrErr  in  1  clears oIllCnt
iTblWe  in  1  table write strobe
iTblAddr  in  OPC_BITS  table write address
iTblCw  in  CW_BITS  control word to store
iTblLat  in  LAT_BITS  extra latency to store

Behaviour:
- Table: 2**OPC_BITS entries of {valid, cw, lat}, held in flops.
  - iTblWe writes {1, iTblCw, iTblLat} at iTblAddr; the new entry is visible to decodes captured from the next cycle on.
  - A decode captured in the same cycle as a write to the same address uses the old entry (read-before-write).
- Reset (iRST=1 at edge, at any point, including mid-stall):
  - all table entries become {0,0,0};
  - state goes to IDLE;
  - oValid=0, oCW=0, oOPC=0, oIllegal=0, oBusy=0, oIllCnt=0, stall counter=0;
  - table writes in the reset cycle are dropped.
- Accept = iValid && oReady. On accept, register oOPC=iOPC and look up entry e=table[iOPC]:
  - e.valid=1: oCW=e.cw, oIllegal=0, store e.lat;
  - e.valid=0: oCW=0, oIllegal=1, stored lat=0, oIllCnt increments and saturates at all-ones.
- Latency: 1 cycle from accept to oValid.
- FSM:
  - IDLE: oValid=0, oReady=1, oBusy=0. Accept -> OUT.
  - OUT: oValid=1, oReady = iReady && (lat==0).
    - iReady=0: hold all outputs stable.
    - iReady=1, lat==0: accept -> stay in OUT with the new decode (full throughput, back-to-back); no accept -> IDLE.
    - iReady=1, lat>0: load counter=lat -> STALL.
  - STALL: oValid=0, oReady=0, oBusy=1; counter decrements each cycle; when counter==1 -> IDLE. STALL lasts exactly lat cycles.
- oCW/oOPC/oIllegal keep their last value when oValid=0 and are don't-care there.
- iClrErr:
  - clears oIllCnt next cycle;
  - if iClrErr and an illegal accept occur in the same cycle, the result is 1.

Optional Feature:
GPPCU_DEC_PERF_EN
- Defined:
  - adds output oStallCnt, 16 bits, reset 0;
  - increments every cycle in STALL, plus every OUT cycle with iReady=0;
  - saturates at 0xFFFF; cleared by iClrErr.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset, then iValid=1 with iOPC=3 (never written) -> next cycle oValid=1, oIllegal=1, oCW=0, oIllCnt=1; 300 further illegal accepts -> oIllCnt=255 (saturated).
2. Write addr 1 cw=0x0A5A3 lat=0; stream opcode 1 for 4 cycles with iReady=1 -> oValid high 4 consecutive cycles, oCW=0x0A5A3, oReady stays 1.
3. Write addr 14 lat=3; accept 14 then iValid=1 with opcode 1 -> after the output handshake: oBusy=1 and oReady=0 for exactly 3 cycles, then IDLE, then opcode 1 accepted.
4. Hold iReady=0 for 5 cycles in OUT -> oValid, oCW, oOPC stable and oReady=0; release -> single handshake, no duplicate output.
5. In one cycle, write addr 2 cw=0x3FFFF and accept opcode 2 (previously cw=0x00001) -> output 0x00001; next accept of 2 -> 0x3FFFF.
6. Assert iRST during STALL with counter=2 -> next cycle IDLE, oBusy=0, oValid=0, oReady=1; opcode 14 now decodes as illegal.

Source files
------------

// File: rtl/gppcu_instr_dec_pipe_if.sv
// ---------------------------------------------------------------------------
// gppcu_instr_dec_pipe_if : handshake, status and table-write bus of the
// registered GPPCU opcode decoder. Optional macro: GPPCU_DEC_PERF_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface gppcu_instr_dec_pipe_if #(
  parameter int OPC_BITS    = 5,
  parameter int CW_BITS     = 18,
  parameter int LAT_BITS    = 4,
  parameter int ERRCNT_BITS = 8
);
  logic                   iValid;
  logic                   oReady;
  logic [OPC_BITS-1:0]    iOPC;
  logic                   oValid;
  logic                   iReady;
  logic [OPC_BITS-1:0]    oOPC;
  logic [CW_BITS-1:0]     oCW;
  logic                   oIllegal;
  logic                   oBusy;
  logic [ERRCNT_BITS-1:0] oIllCnt;
  logic                   iClrErr;
  logic                   iTblWe;
  logic [OPC_BITS-1:0]    iTblAddr;
  logic [CW_BITS-1:0]     iTblCw;
  logic [LAT_BITS-1:0]    iTblLat;
`ifdef GPPCU_DEC_PERF_EN
  logic [15:0]            oStallCnt;
`endif

  modport slave (
    input  iValid, iOPC, iReady, iClrErr, iTblWe, iTblAddr, iTblCw, iTblLat,
`ifdef GPPCU_DEC_PERF_EN
    output oStallCnt,
`endif
    output oReady, oValid, oOPC, oCW, oIllegal, oBusy, oIllCnt
  );

  modport master (
    output iValid, iOPC, iReady, iClrErr, iTblWe, iTblAddr, iTblCw, iTblLat,
`ifdef GPPCU_DEC_PERF_EN
    input  oStallCnt,
`endif
    input  oReady, oValid, oOPC, oCW, oIllegal, oBusy, oIllCnt
  );
endinterface

`default_nettype wire

// File: rtl/gppcu_instr_dec_pipe.sv
// ---------------------------------------------------------------------------
// gppcu_instr_dec_pipe : registered, run-time programmable opcode decoder with
// valid/ready handshakes and post-op latency stall. Optional: GPPCU_DEC_PERF_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gppcu_instr_dec_pipe #(
  parameter int OPC_BITS    = 5,
  parameter int CW_BITS     = 18,
  parameter int LAT_BITS    = 4,
  parameter int ERRCNT_BITS = 8
) (
  input  wire logic iCLK,
  input  wire logic iRST,
  gppcu_instr_dec_pipe_if.slave bus
);
  localparam int DEPTH = 2 ** OPC_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OUT   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t                 state;
  logic                   tbl_vld [DEPTH];
  logic [CW_BITS-1:0]     tbl_cw  [DEPTH];
  logic [LAT_BITS-1:0]    tbl_lat [DEPTH];

  logic [OPC_BITS-1:0]    opc_q;
  logic [CW_BITS-1:0]     cw_q;
  logic                   ill_q;
  logic [LAT_BITS-1:0]    lat_q;
  logic [LAT_BITS-1:0]    stall_cnt;
  logic [ERRCNT_BITS-1:0] ill_cnt;

  logic ready;
  logic accept;
  logic ill_accept;

  // Back-to-back acceptance only when the current output carries no stall.
  always_comb begin
    ready = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_OUT:   ready = bus.iReady && (lat_q == '0);
      default: ready = 1'b0;
    endcase
  end

  assign accept     = bus.iValid && ready;
  assign ill_accept = accept && !tbl_vld[bus.iOPC];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_vld[i] <= 1'b0;
        tbl_cw[i]  <= '0;
        tbl_lat[i] <= '0;
      end
      state     <= S_IDLE;
      opc_q     <= '0;
      cw_q      <= '0;
      ill_q     <= 1'b0;
      lat_q     <= '0;
      stall_cnt <= '0;
      ill_cnt   <= '0;
    end else begin
      // Lookups below read the pre-write table contents.
      if (bus.iTblWe) begin
        tbl_vld[bus.iTblAddr] <= 1'b1;
        tbl_cw[bus.iTblAddr]  <= bus.iTblCw;
        tbl_lat[bus.iTblAddr] <= bus.iTblLat;
      end

      if (accept) begin
        opc_q <= bus.iOPC;
        if (tbl_vld[bus.iOPC]) begin
          cw_q  <= tbl_cw[bus.iOPC];
          ill_q <= 1'b0;
          lat_q <= tbl_lat[bus.iOPC];
        end else begin
          cw_q  <= '0;
          ill_q <= 1'b1;
          lat_q <= '0;
        end
      end

      case (state)
        S_IDLE: begin
          if (accept) state <= S_OUT;
        end
        S_OUT: begin
          if (bus.iReady) begin
            if (lat_q != '0) begin
              stall_cnt <= lat_q;
              state     <= S_STALL;
            end else if (!accept) begin
              state <= S_IDLE;
            end
          end
        end
        S_STALL: begin
          stall_cnt <= stall_cnt - 1'b1;
          if (stall_cnt == LAT_BITS'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (bus.iClrErr)
        ill_cnt <= ill_accept ? ERRCNT_BITS'(1) : '0;
      else if (ill_accept && (ill_cnt != '1))
        ill_cnt <= ill_cnt + 1'b1;
    end
  end

  assign bus.oReady   = ready;
  assign bus.oValid   = (state == S_OUT);
  assign bus.oBusy    = (state == S_STALL);
  assign bus.oOPC     = opc_q;
  assign bus.oCW      = cw_q;
  assign bus.oIllegal = ill_q;
  assign bus.oIllCnt  = ill_cnt;

`ifdef GPPCU_DEC_PERF_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      perf_cnt <= '0;
    end else if (bus.iClrErr) begin
      perf_cnt <= '0;
    end else if (((state == S_STALL) || ((state == S_OUT) && !bus.iReady))
                 && (perf_cnt != 16'hFFFF)) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end

  assign bus.oStallCnt = perf_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gppcu_instr_dec_pipe.sv
// ---------------------------------------------------------------------------
// tb_gppcu_instr_dec_pipe : directed self-checking bench for the decoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gppcu_instr_dec_pipe;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  gppcu_instr_dec_pipe_if #(.OPC_BITS(5), .CW_BITS(18), .LAT_BITS(4), .ERRCNT_BITS(8)) bus ();

  gppcu_instr_dec_pipe #(.OPC_BITS(5), .CW_BITS(18), .LAT_BITS(4), .ERRCNT_BITS(8)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tbl_write(input logic [4:0] addr, input logic [17:0] cw, input logic [3:0] lat);
    bus.iTblWe   = 1'b1;
    bus.iTblAddr = addr;
    bus.iTblCw   = cw;
    bus.iTblLat  = lat;
    tick();
    bus.iTblWe   = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.iValid   = 1'b0;
    bus.iOPC     = '0;
    bus.iReady   = 1'b0;
    bus.iClrErr  = 1'b0;
    bus.iTblWe   = 1'b0;
    bus.iTblAddr = '0;
    bus.iTblCw   = '0;
    bus.iTblLat  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", bus.oValid, 0);
    check("rst_ready", bus.oReady, 1);
    check("rst_busy", bus.oBusy, 0);
    check("rst_cw", bus.oCW, 0);
    check("rst_opc", bus.oOPC, 0);
    check("rst_illcnt", bus.oIllCnt, 0);

    // Illegal opcode decode and counter saturation
    bus.iValid = 1'b1;
    bus.iOPC   = 5'd3;
    tick();
    check("ill_valid", bus.oValid, 1);
    check("ill_flag", bus.oIllegal, 1);
    check("ill_cw", bus.oCW, 0);
    check("ill_opc", bus.oOPC, 3);
    check("ill_cnt1", bus.oIllCnt, 1);
    bus.iReady = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    check("ill_cnt_sat", bus.oIllCnt, 255);
    bus.iClrErr = 1'b1;
    tick();
    check("clr_with_ill", bus.oIllCnt, 1);
    bus.iValid = 1'b0;
    tick();
    check("clr_only", bus.oIllCnt, 0);
    check("clr_idle", bus.oValid, 0);
    bus.iClrErr = 1'b0;

    // Full-throughput streaming of a zero-latency entry
    tbl_write(5'd1, 18'h0A5A3, 4'd0);
    bus.iValid = 1'b1;
    bus.iOPC   = 5'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("strm_valid", bus.oValid, 1);
      check("strm_cw", bus.oCW, 18'h0A5A3);
      check("strm_ill", bus.oIllegal, 0);
      check("strm_ready", bus.oReady, 1);
    end
    bus.iValid = 1'b0;
    tick();
    check("strm_end", bus.oValid, 0);
    check("strm_illcnt", bus.oIllCnt, 0);

    // Latency stall after a long op
    tbl_write(5'd14, 18'h12345, 4'd3);
    bus.iValid = 1'b1;
    bus.iOPC   = 5'd14;
    tick();
    check("lat_valid", bus.oValid, 1);
    check("lat_cw", bus.oCW, 18'h12345);
    check("lat_ready", bus.oReady, 0);
    bus.iOPC = 5'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_busy", bus.oBusy, 1);
      check("stall_ready", bus.oReady, 0);
      check("stall_valid", bus.oValid, 0);
    end
    tick();
    check("post_busy", bus.oBusy, 0);
    check("post_ready", bus.oReady, 1);
    check("post_valid", bus.oValid, 0);
    tick();
    check("after_opc", bus.oOPC, 1);
    check("after_cw", bus.oCW, 18'h0A5A3);
    check("after_valid", bus.oValid, 1);

    // Downstream backpressure holds the output
    bus.iReady = 1'b0;
    bus.iOPC   = 5'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", bus.oValid, 1);
      check("hold_opc", bus.oOPC, 1);
      check("hold_cw", bus.oCW, 18'h0A5A3);
      check("hold_ready", bus.oReady, 0);
    end
    bus.iValid = 1'b0;
    bus.iReady = 1'b1;
    tick();
    check("hold_release", bus.oValid, 0);
    check("hold_noacc", bus.oIllCnt, 0);

    // Read-before-write on a same-cycle table update
    tbl_write(5'd2, 18'h00001, 4'd0);
    bus.iTblWe   = 1'b1;
    bus.iTblAddr = 5'd2;
    bus.iTblCw   = 18'h3FFFF;
    bus.iTblLat  = 4'd0;
    bus.iValid   = 1'b1;
    bus.iOPC     = 5'd2;
    tick();
    bus.iTblWe = 1'b0;
    check("rbw_old", bus.oCW, 18'h00001);
    tick();
    check("rbw_new", bus.oCW, 18'h3FFFF);
    bus.iValid = 1'b0;
    tick();
    check("rbw_idle", bus.oValid, 0);

    // Reset in the middle of a stall; table writes during reset are dropped
    bus.iValid = 1'b1;
    bus.iOPC   = 5'd14;
    tick();
    bus.iValid = 1'b0;
    tick();
    check("mid_busy", bus.oBusy, 1);
    tick();
    rst          = 1'b1;
    bus.iTblWe   = 1'b1;
    bus.iTblAddr = 5'd5;
    bus.iTblCw   = 18'h00007;
    tick();
    rst        = 1'b0;
    bus.iTblWe = 1'b0;
    check("mrst_busy", bus.oBusy, 0);
    check("mrst_valid", bus.oValid, 0);
    check("mrst_ready", bus.oReady, 1);
    check("mrst_illcnt", bus.oIllCnt, 0);
    bus.iValid = 1'b1;
    bus.iOPC   = 5'd14;
    tick();
    check("mrst_14_ill", bus.oIllegal, 1);
    check("mrst_14_cw", bus.oCW, 0);
    check("mrst_14_cnt", bus.oIllCnt, 1);
    bus.iOPC = 5'd5;
    tick();
    check("mrst_5_opc", bus.oOPC, 5);
    check("mrst_5_ill", bus.oIllegal, 1);
    check("mrst_5_cnt", bus.oIllCnt, 2);
    bus.iValid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

`default_nettype wire
